program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream (host/UART side) and writes assembled instruction words into instruction memory's write port, starting at address 0.
- Holds the CPU in reset for the whole load. `cpuHold` drives the CPU's `isReset`.
- Releases the CPU once the checksum verifies. The CPU then fetches from pc 0 the program just written.

Parameters:
- INSTRUCTION_WIDTH, 32, instruction word width; must be a multiple of 8.
- PC_WIDTH, 8, instruction memory address width.
- BYTES_PER_WORD, INSTRUCTION_WIDTH/8, bytes per instruction word (derived, not overridden).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  in  1  system clock, all state on rising edge.
- isReset  in  1  reset, asynchronous, active-high.
- byteValid  in  1  source has a byte on byteData.
- byteData  in  8  stream byte.
- byteReady  out  1  loader accepts a byte this cycle. Transfer = byteValid & byteReady.
- writeEnable  out  1  one-cycle memory write strobe.
- writeAddress  out  PC_WIDTH  memory address for the write.
- writeData  out  INSTRUCTION_WIDTH  instruction word for the write.
- cpuHold  out  1  CPU held in reset; connects to CPU isReset.
- loadDone  out  1  one-cycle pulse: frame accepted and checksum good.
- loadError  out  1  sticky: last frame had a bad checksum.

Behaviour:
- Frame format: SYNC_BYTE, count N (8-bit, number of words), N*BYTES_PER_WORD payload bytes MSB-first, checksum.
- Checksum = sum of payload bytes mod 256. Sync and count bytes are excluded.

Reset (async):
- State IDLE, address counter 0, word shifter 0, checksum 0.
- All outputs 0, except byteReady = 1.

State machine:
- IDLE:
  - cpuHold = 0; bytes other than SYNC_BYTE are accepted and discarded.
  - SYNC_BYTE goes to COUNT. On that transition: clear loadError, checksum, address, and byte index.
- COUNT:
  - Latch N.
  - N = 0 goes to CHECK; otherwise goes to DATA.
- DATA:
  - Each transfer: word = {word[W-9:0], byteData}; checksum += byteData; byte index++.
  - On the BYTES_PER_WORD-th byte:
    - Next cycle: writeEnable = 1, writeAddress = address, writeData = full word.
    - Then address++ and remaining--; when remaining reaches 0, go to CHECK.
  - SYNC_BYTE inside DATA is ordinary payload.
- CHECK:
  - Transfer with byteData == checksum goes to DONE.
  - Any other value: loadError <= 1, go to IDLE.
  - Words already written stay written; no rollback.
- DONE (one cycle):
  - loadDone = 1, byteReady = 0, then go to IDLE.

Output rules:
- cpuHold = (state != IDLE), registered. It rises the cycle after the sync transfer and falls the cycle after DONE or a checksum failure.
- byteReady = 1 in every state except DONE.
- Write latency: writeEnable is asserted exactly 1 cycle after the final byte of a word is transferred. Never more than one write per BYTES_PER_WORD transfers.

Width and boundary rules:
- Address wraps modulo 2^PC_WIDTH. With N >= 2^PC_WIDTH, later words overwrite earlier ones.
- Checksum wraps modulo 256.
- byteValid gaps anywhere in a frame stall the loader with no state change and no timeout.

Reset mid-load:
- Immediate return to IDLE with cpuHold = 0.
- A partial word is dropped, never written.
- Memory keeps the words written before reset.

Decomposition:
- Package loader_pkg:
  - state enum {IDLE, COUNT, DATA, CHECK, DONE};
  - SYNC_BYTE default;
  - BYTES_PER_WORD function.
- INSTRUCTION_WIDTH and PC_WIDTH come from parameters.h.
- One sub-module, word_assembler:
  - byte shifter plus byte index;
  - inputs shift and clear; outputs word and wordComplete.

Test Plan:
1. Stream 00 FF 3C with no sync → no writes, cpuHold stays 0, loadDone never pulses.
2. A5 02 01 02 03 04 05 06 07 08 24 → writes addr0 = 32'h01020304 and addr1 = 32'h05060708, loadDone pulses once, loadError = 0, cpuHold drops the cycle after DONE.
3. Same frame with checksum 25 → both words written, loadError = 1, no loadDone, cpuHold drops. A following good frame clears loadError.
4. Frame 2 with byteValid low for 3 cycles between every byte → identical writes and timing relative to transfers.
5. A5 00 00 → no writes, loadDone pulses. A5 00 01 → loadError = 1.
6. isReset asserted after 6 payload bytes of frame 2 → addr0 written, addr1 never written, cpuHold = 0 at once, all outputs at reset values.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
// Provides the loader state enum, the default frame sync marker and
// the bytes-per-word helper used by the loader and its word assembler.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE} state_t;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: shifts stream bytes MSB-first into an instruction word.
// Ports: clock/isReset (async active-high), shift (accept byteData),
// clear (drop partial word), word (assembled word), lastByte (next shift
// completes a word), wordComplete (registered pulse after the final byte).
module word_assembler
  import loader_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         shift,
  input  logic                         clear,
  input  logic [7:0]                   byteData,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         lastByte,
  output logic                         wordComplete
);
  localparam int BPW = bytes_per_word(INSTRUCTION_WIDTH);
  localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
  logic [INSTRUCTION_WIDTH-1:0] r_word;
  logic [IW-1:0]                r_idx;
  logic                         r_complete;
  assign lastByte = r_idx == IW'(BPW - 1);
  assign word = r_word;
  assign wordComplete = r_complete;
  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      r_word <= '0;
      r_idx <= '0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= shift && lastByte;
      if (clear) begin
        r_word <= '0;
        r_idx <= '0;
      end else if (shift) begin
        r_word <= (r_word << 8) | INSTRUCTION_WIDTH'(byteData);
        r_idx <= lastByte ? '0 : r_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: writes a framed byte stream into instruction memory and holds the CPU in reset meanwhile.
// Ports: clock, isReset (async active-high); byteValid/byteData/byteReady
// stream handshake; writeEnable/writeAddress/writeData memory write port;
// cpuHold to CPU reset; loadDone pulse on good checksum; loadError sticky.
module program_loader
  import loader_pkg::*;
#(
  parameter int         INSTRUCTION_WIDTH = 32,
  parameter int         PC_WIDTH          = 8,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         byteValid,
  input  logic [7:0]                   byteData,
  output logic                         byteReady,
  output logic                         writeEnable,
  output logic [PC_WIDTH-1:0]          writeAddress,
  output logic [INSTRUCTION_WIDTH-1:0] writeData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError
);
  state_t              r_state, w_next;
  logic [PC_WIDTH-1:0] r_addr;
  logic [7:0]          r_remaining;
  logic [7:0]          r_sum;
  logic                r_hold;
  logic                r_err;
  logic                w_xfer, w_sync, w_shift, w_last, w_complete;
  assign byteReady = r_state != DONE;
  assign loadDone = r_state == DONE;
  assign cpuHold = r_hold;
  assign loadError = r_err;
  assign writeEnable = w_complete;
  assign writeAddress = r_addr;
  assign w_xfer = byteValid && byteReady;
  assign w_sync = r_state == IDLE && w_xfer && byteData == SYNC_BYTE;
  assign w_shift = r_state == DATA && w_xfer;
  word_assembler #(.INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)) u_asm (
    .clock        (clock),
    .isReset      (isReset),
    .shift        (w_shift),
    .clear        (w_sync),
    .byteData     (byteData),
    .word         (writeData),
    .lastByte     (w_last),
    .wordComplete (w_complete)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_sync ? COUNT : IDLE;
      COUNT: w_next = !w_xfer ? COUNT : byteData == 8'd0 ? CHECK : DATA;
      // leave DATA on the final payload byte so the checksum byte can
      // arrive while the last word's write is still in flight
      DATA:  w_next = w_shift && w_last && r_remaining == 8'd1 ? CHECK : DATA;
      CHECK: w_next = !w_xfer ? CHECK : byteData == r_sum ? DONE : IDLE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_remaining <= '0;
      r_sum <= '0;
      r_hold <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold <= w_next != IDLE;
      if (w_sync) begin
        r_err <= 1'b0;
        r_sum <= '0;
        r_addr <= '0;
      end
      if (w_complete) r_addr <= r_addr + 1'b1;
      if (r_state == COUNT && w_xfer) r_remaining <= byteData;
      if (w_shift) begin
        r_sum <= r_sum + byteData;
        if (w_last) r_remaining <= r_remaining - 8'd1;
      end
      if (r_state == CHECK && w_xfer && byteData != r_sum) r_err <= 1'b1;
    end
  end
endmodule
